fp_mul_scheduler: RTL and testbench
===================================

# fp_mul_scheduler

Round-robin scheduler that shares one combinational IEEE-754 single-precision multiplier among `NUM_REQ` requesters. Each accepted request is registered, presented to the external shared multiplier, and its result and flags are captured with the requester ID. The block then returns them on a single tagged response channel. It sits between the compute lanes and the multiplier datapath, so the block is the only driver of the multiplier operands.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, from 2 to 16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID tag.

Ports:
- `clk`, input, 1: the only clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, `NUM_REQ`: per-requester request valid.
- `req_ready`, output, `NUM_REQ`: per-requester grant. At most one bit is high in any cycle.
- `req_a`, input, `NUM_REQ*32`: operand A. Requester i uses bits `[32i+31:32i]`.
- `req_b`, input, `NUM_REQ*32`: operand B, packed the same way as `req_a`.
- `mul_a`, output, 32: operand A to the shared multiplier.
- `mul_b`, output, 32: operand B to the shared multiplier.
- `mul_result`, input, 32: multiplier result.
- `mul_exception`, input, 1: multiplier exception flag.
- `mul_overflow`, input, 1: multiplier overflow flag.
- `mul_underflow`, input, 1: multiplier underflow flag.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: response consumer ready.
- `rsp_id`, output, `ID_W`: index of the requester that issued the operation.
- `rsp_result`, output, 32: product.
- `rsp_flags`, output, 3: `{exception, overflow, underflow}`.

## Operation

- The block is a two-stage pipeline.
  - S1 (issue) holds `s1_valid`, `s1_a`, `s1_b` and `s1_id`.
  - S2 (result) holds `s2_valid`, result, flags and ID.
- The multiplier is combinational. `mul_a` = `s1_a` and `mul_b` = `s1_b` when `s1_valid`. Both are 32'd0 when S1 is empty, to gate toggling.
- Stall rules:
  - `s2_adv = !s2_valid | rsp_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
- S2 captures `mul_result`, the flags and `s1_id` when `s1_valid & s2_adv`. It clears when it drains with S1 empty.
- Arbitration:
  - When `s1_adv`, grant the first requester with `req_valid` set, searching from `rr_ptr` upward with modulo `NUM_REQ` wrap.
  - `req_ready[g]` = 1 for the granted requester only. A transfer occurs when `req_valid[g] & req_ready[g]`.
  - On a transfer, `rr_ptr` becomes `(g+1) mod NUM_REQ`. Otherwise `rr_ptr` holds.
- `req_ready` depends combinationally on `req_valid`. A requester must not make `req_valid` depend on `req_ready`. A requester holds `req_valid` and its operands until its transfer.
- The block does not modify results or flags. It passes `mul_*` through exactly, including the zero result that accompanies an exception.
- Responses return in issue order. The block buffers at most 2 operations.
- Reset clears everything:
  - `s1_valid`, `s2_valid` and `rr_ptr` go to 0.
  - `req_ready`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_flags`, `mul_a` and `mul_b` read 0.
  - Operations in flight when `rst_n` asserts are discarded with no response.

## Timing

- Latency: a transfer at edge N gives `rsp_valid` = 1 in the cycle after edge N+1. The response therefore appears 2 edges after acceptance.
- Throughput is 1 operation per cycle while `rsp_ready` = 1.
- Backpressure with `rsp_ready` = 0:
  - S2 holds its contents stable, and `rsp_*` must not change while `rsp_valid & !rsp_ready`.
  - S1 accepts one more operation, then `req_ready` stays all-zero until S2 drains.
- Simultaneous drain and accept: if S2 drains, S1 moves into S2 and a new request enters S1 in the same edge. There is no bubble.
- Wrap: from `rr_ptr` = `NUM_REQ-1`, the search order is `NUM_REQ-1`, 0, 1, and so on.
- Deassertion of `rst_n` is synchronised externally. The first grant may occur in the first cycle after release.

## Test plan

- Single op:
  - Stimulus: requester 2 sends 0x3FC00000 × 0x40000000, with `rsp_ready` = 1.
  - Response: 2 edges later, `rsp_valid` = 1, `rsp_id` = 2, `rsp_result` = 0x40400000, `rsp_flags` = 3'b000.
- Fairness:
  - Stimulus: all 4 requesters hold `req_valid` high for 8 cycles.
  - Response: grants go in order 0,1,2,3,0,1,2,3. `rsp_id` follows the same order, with one response per cycle.
- Backpressure:
  - Stimulus: hold `rsp_ready` = 0 for 4 cycles with continuous requests.
  - Response: exactly 2 operations are accepted, `rsp_*` stay stable, and no operation is lost or duplicated after release.
- Flags:
  - 0x7F000000 × 0x7F000000 gives 0x7F800000 with flags 3'b010.
  - 0x00800000 × 0x00800000 gives 0x00000000 with flags 3'b001.
  - 0x7F800000 × 0x3F800000 gives 0x00000000 with flags 3'b100.
- Reset mid-operation:
  - Stimulus: assert `rst_n` = 0 with S1 and S2 both full.
  - Response: all outputs go to 0 immediately and no response is produced. After release, requester 0 has first priority.
- Wrap and sparse:
  - Stimulus: `rr_ptr` = 3, and only requesters 1 and 3 are valid.
  - Response: 3 is granted, then 1. `rr_ptr` ends at 2.

Source files
------------

// File: rtl/fp_mul_scheduler_if.sv
// Bundles the request, shared-multiplier and response channels of fp_mul_scheduler.
// master is the scheduler side; slave is the requesters, multiplier and consumer side.
interface fp_mul_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic [31:0]           mul_result;
    logic                  mul_exception;
    logic                  mul_overflow;
    logic                  mul_underflow;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic [2:0]            rsp_flags;

    modport master (
        input  req_valid, req_a, req_b,
        input  mul_result, mul_exception, mul_overflow, mul_underflow,
        input  rsp_ready,
        output req_ready, mul_a, mul_b,
        output rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport slave (
        output req_valid, req_a, req_b,
        output mul_result, mul_exception, mul_overflow, mul_underflow,
        output rsp_ready,
        input  req_ready, mul_a, mul_b,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one combinational FP32 multiplier among NUM_REQ requesters.
// Two-stage pipeline: S1 drives the multiplier operands, S2 holds the tagged response.
module fp_mul_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input logic                clk,
    input logic                rst_n,
    fp_mul_scheduler_if.master bus
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               s1_valid_q, s1_valid_d;
    logic [31:0]        s1_a_q, s1_a_d;
    logic [31:0]        s1_b_q, s1_b_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               s2_valid_q, s2_valid_d;
    logic [31:0]        s2_result_q, s2_result_d;
    logic [2:0]         s2_flags_q, s2_flags_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;

    logic               s2_adv, s1_adv;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic               transfer;
    logic [NUM_REQ-1:0] req_ready;

    assign s2_adv = !s2_valid_q || bus.rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + 32'(k)) % NUM_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    // rst_n gates the grant so req_ready reads zero while reset is held.
    assign transfer = grant_found && s1_adv && rst_n;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        s2_id_d     = s2_id_q;

        if (transfer) begin
            rr_ptr_d = PTR_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
        end

        if (s1_adv) begin
            s1_valid_d = transfer;
            if (transfer) begin
                s1_a_d  = bus.req_a[32*int'(grant_idx) +: 32];
                s1_b_d  = bus.req_b[32*int'(grant_idx) +: 32];
                s1_id_d = ID_W'(grant_idx);
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = bus.mul_result;
                s2_flags_d  = {bus.mul_exception, bus.mul_overflow, bus.mul_underflow};
                s2_id_d     = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            s2_id_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            s2_id_q     <= s2_id_d;
        end
    end

    // Operands are zeroed when S1 is empty to keep the multiplier quiet.
    assign bus.req_ready  = req_ready;
    assign bus.mul_a      = s1_valid_q ? s1_a_q : 32'd0;
    assign bus.mul_b      = s1_valid_q ? s1_b_q : 32'd0;
    assign bus.rsp_valid  = s2_valid_q;
    assign bus.rsp_id     = s2_valid_q ? s2_id_q : '0;
    assign bus.rsp_result = s2_valid_q ? s2_result_q : 32'd0;
    assign bus.rsp_flags  = s2_valid_q ? s2_flags_q : 3'd0;
endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Self-checking bench for fp_mul_scheduler: table-driven vectors, a scoreboard of expected
// responses, and directed sequences for fairness, backpressure, reset and wrap.
module tb_fp_mul_scheduler;
    localparam int NR = 4;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
        logic [2:0]  flags;
    } exp_t;

    logic clk;
    logic rst_n;

    fp_mul_scheduler_if #(.NUM_REQ(NR)) bus ();

    fp_mul_scheduler #(.NUM_REQ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in multiplier: known vectors return true IEEE products, others a mixing hash.
    function automatic logic [34:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3FC00000, 32'h40000000}: fake_mul = {3'b000, 32'h40400000};
            {32'h7F000000, 32'h7F000000}: fake_mul = {3'b010, 32'h7F800000};
            {32'h00800000, 32'h00800000}: fake_mul = {3'b001, 32'h00000000};
            {32'h7F800000, 32'h3F800000}: fake_mul = {3'b100, 32'h00000000};
            default: fake_mul = {a[2:0] ^ b[5:3], a ^ {b[15:0], b[31:16]}};
        endcase
    endfunction

    always_comb begin
        {bus.mul_exception, bus.mul_overflow, bus.mul_underflow, bus.mul_result} =
            fake_mul(bus.mul_a, bus.mul_b);
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   remaining [NR];
    exp_t sb [$];
    int   grants [$];
    int   rsp_log [$];
    int   rsp_cyc [$];
    bit   hold;
    logic [1:0]  prev_id;
    logic [31:0] prev_res;
    logic [2:0]  prev_flags;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic request(input int i, input int n, input logic [31:0] a, input logic [31:0] b);
        set_op(i, a, b);
        remaining[i]     = n;
        bus.req_valid[i] = 1'b1;
    endtask

    // Called at a negedge with inputs settled; observes what the next posedge will do.
    task automatic cycle();
        bit   xfer [NR];
        exp_t e;
        #1;
        chk("req_ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
        if (hold) begin
            chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("stall_rsp_id", 64'(bus.rsp_id), 64'(prev_id));
            chk("stall_rsp_result", 64'(bus.rsp_result), 64'(prev_res));
            chk("stall_rsp_flags", 64'(bus.rsp_flags), 64'(prev_flags));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                chk("rsp_result", 64'(bus.rsp_result), 64'(e.res));
                chk("rsp_flags", 64'(bus.rsp_flags), 64'(e.flags));
            end
            rsp_log.push_back(int'(bus.rsp_id));
            rsp_cyc.push_back(cyc);
        end
        hold       = bus.rsp_valid && !bus.rsp_ready;
        prev_id    = bus.rsp_id;
        prev_res   = bus.rsp_result;
        prev_flags = bus.rsp_flags;
        for (int i = 0; i < NR; i++) begin
            xfer[i] = 1'b0;
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                xfer[i] = 1'b1;
                e.id    = 2'(i);
                {e.flags, e.res} = fake_mul(bus.req_a[i*32 +: 32], bus.req_b[i*32 +: 32]);
                sb.push_back(e);
                grants.push_back(i);
                remaining[i]--;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (xfer[i]) begin
                if (remaining[i] <= 0) bus.req_valid[i] = 1'b0;
                else set_op(i, $urandom, $urandom);
            end
        end
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((sb.size() != 0 || bus.req_valid != '0 || bus.rsp_valid) && n < max_cycles) begin
            cycle();
            n++;
        end
        if (n >= max_cycles) chk("drain_timeout", 64'(n), 64'(max_cycles - 1));
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < NR; i++) remaining[i] = 0;
        sb.delete();
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
        chk({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'd0);
        chk({tag, "_rsp_flags"}, 64'(bus.rsp_flags), 64'd0);
        chk({tag, "_mul_a"}, 64'(bus.mul_a), 64'd0);
        chk({tag, "_mul_b"}, 64'(bus.mul_b), 64'd0);
    endtask

    initial begin
        vecs[0] = '{id: 2, a: 32'h3FC00000, b: 32'h40000000, res: 32'h40400000, flags: 3'b000};
        vecs[1] = '{id: 0, a: 32'h7F000000, b: 32'h7F000000, res: 32'h7F800000, flags: 3'b010};
        vecs[2] = '{id: 1, a: 32'h00800000, b: 32'h00800000, res: 32'h00000000, flags: 3'b001};
        vecs[3] = '{id: 3, a: 32'h7F800000, b: 32'h3F800000, res: 32'h00000000, flags: 3'b100};

        rst_n         = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < NR; i++) begin
            set_op(i, $urandom, $urandom);
            remaining[i] = 0;
        end
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        bus.req_valid = '0;
        rst_n         = 1'b1;
        @(negedge clk);

        // Table-driven single operations, checking exact latency and passthrough.
        for (int v = 0; v < 4; v++) begin
            request(vecs[v].id, 1, vecs[v].a, vecs[v].b);
            cycle();
            chk("lat_rsp_valid_n", 64'(bus.rsp_valid), 64'd0);
            chk("s1_mul_a", 64'(bus.mul_a), 64'(vecs[v].a));
            chk("s1_mul_b", 64'(bus.mul_b), 64'(vecs[v].b));
            cycle();
            chk("vec_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("vec_rsp_id", 64'(bus.rsp_id), 64'(vecs[v].id));
            chk("vec_rsp_result", 64'(bus.rsp_result), 64'(vecs[v].res));
            chk("vec_rsp_flags", 64'(bus.rsp_flags), 64'(vecs[v].flags));
            chk("idle_mul_a", 64'(bus.mul_a), 64'd0);
            drain(10);
        end

        // Fairness: all four requesters continuously valid from rr_ptr = 0.
        do_reset();
        for (int i = 0; i < NR; i++) request(i, 2, $urandom, $urandom);
        grants.delete();
        rsp_log.delete();
        rsp_cyc.delete();
        repeat (8) cycle();
        chk("fair_grant_count", 64'(grants.size()), 64'd8);
        for (int k = 0; k < 8 && k < grants.size(); k++) chk("fair_grant_order", 64'(grants[k]), 64'(k % 4));
        drain(20);
        chk("fair_rsp_count", 64'(rsp_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < rsp_log.size(); k++) chk("fair_rsp_order", 64'(rsp_log[k]), 64'(k % 4));
        if (rsp_cyc.size() == 8) chk("fair_rsp_back_to_back", 64'(rsp_cyc[7] - rsp_cyc[0]), 64'd7);

        // Backpressure: consumer stalled for 4 cycles under continuous requests.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) request(i, 3, $urandom, $urandom);
        grants.delete();
        rsp_log.delete();
        repeat (4) cycle();
        chk("bp_accepted", 64'(grants.size()), 64'd2);
        chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
        bus.rsp_ready = 1'b1;
        drain(40);
        chk("bp_total_grants", 64'(grants.size()), 64'd12);
        chk("bp_total_rsps", 64'(rsp_log.size()), 64'd12);

        // Reset with both stages full: everything clears, in-flight ops vanish.
        bus.rsp_ready = 1'b0;
        request(1, 1, 32'h11111111, 32'h01010101);
        request(2, 1, 32'h22222222, 32'h02020202);
        cycle();
        cycle();
        chk("rst_pre_s2_full", 64'(bus.rsp_valid), 64'd1);
        chk("rst_pre_s1_full", 64'(bus.mul_a == 32'h11111111 || bus.mul_a == 32'h22222222), 64'd1);
        request(3, 1, 32'h33333333, 32'h03030303);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        sb.delete();
        hold          = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < NR; i++) remaining[i] = 0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        request(0, 1, $urandom, $urandom);
        request(3, 1, $urandom, $urandom);
        grants.delete();
        rsp_log.delete();
        cycle();
        chk("post_rst_first_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);
        drain(20);
        chk("post_rst_rsp_count", 64'(rsp_log.size()), 64'd2);

        // Wrap and sparse: rr_ptr = 3 with only requesters 1 and 3 valid.
        request(2, 1, $urandom, $urandom);
        drain(20);
        grants.delete();
        request(1, 1, $urandom, $urandom);
        request(3, 1, $urandom, $urandom);
        drain(20);
        chk("wrap_grant_count", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            chk("wrap_first", 64'(grants[0]), 64'd3);
            chk("wrap_second", 64'(grants[1]), 64'd1);
        end
        grants.delete();
        for (int i = 0; i < NR; i++) request(i, 1, $urandom, $urandom);
        drain(20);
        chk("wrap_ptr_grant_count", 64'(grants.size()), 64'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++) chk("wrap_ptr_order", 64'(grants[k]), 64'((k + 2) % 4));
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
